// File: rtl/neural_soc_debug_pkg.sv
// Shared definitions for the OCI debug access arbiter.
package neural_soc_debug_pkg;

    localparam int unsigned DEF_ADDR_W  = 9;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    // Requester indices into valid/ready/grant vectors.
    localparam int unsigned REQ_J = 0;
    localparam int unsigned REQ_A = 1;

    // Arbiter FSM encoding.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_RESPOND  = 2'd3;

    typedef logic [1:0] state_t;

    // One-hot grant vector ({a,j}) from a requester index bit.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/neural_soc_debug_rr_pick.sv
// Two-way round-robin pick with a JTAG priority override while in debug mode.
module neural_soc_debug_rr_pick
    import neural_soc_debug_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       debugack,
    output logic [1:0] winner_c
);

    // Priority override first, then single requester, then alternate on a tie.
    always_comb begin
        winner_c = 2'b00;
        if (debugack && valid[REQ_J]) begin
            winner_c = 2'b01;
        end else if (valid == 2'b11) begin
            winner_c = (last_grant == 1'(REQ_A)) ? 2'b01 : 2'b10;
        end else begin
            winner_c = valid;
        end
    end

endmodule

// File: rtl/neural_soc_debug_access_arbiter.sv
// Arbitrates the single OCI debug port between the JTAG and Avalon requesters.
module neural_soc_debug_access_arbiter
    import neural_soc_debug_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              j_req_valid,
    output logic              j_req_ready,
    input  logic              j_req_write,
    input  logic [ADDR_W-1:0] j_req_addr,
    input  logic [DATA_W-1:0] j_req_wdata,
    output logic              j_rsp_valid,
    output logic [DATA_W-1:0] j_rsp_rdata,
    output logic              j_rsp_err,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    output logic              a_rsp_err,

    input  logic              debugack,

    output logic              m_valid,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rdata_valid,
    input  logic [DATA_W-1:0] m_rdata,

    output logic [1:0]        grant,
    output logic              busy
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                timeout_c;
    logic [1:0]          winner_c;

    neural_soc_debug_rr_pick u_pick (
        .valid      ({a_req_valid, j_req_valid}),
        .last_grant (last_grant_q),
        .debugack   (debugack),
        .winner_c   (winner_c)
    );

    assign timeout_c = (timer_q == TMR_W'(TIMEOUT));

    // Next-state, latched-field and ready logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        timer_d      = timer_q;
        j_req_ready  = 1'b0;
        a_req_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                j_req_ready = winner_c[REQ_J];
                a_req_ready = winner_c[REQ_A];
                if (winner_c[REQ_A]) begin
                    owner_d = 1'(REQ_A);
                    wr_d    = a_req_write;
                    addr_d  = a_req_addr;
                    wdata_d = a_req_wdata;
                end else if (winner_c[REQ_J]) begin
                    owner_d = 1'(REQ_J);
                    wr_d    = j_req_write;
                    addr_d  = j_req_addr;
                    wdata_d = j_req_wdata;
                end
                if (|winner_c) begin
                    timer_d = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                timer_d = timeout_c ? timer_q : timer_q + TMR_W'(1);
                if (m_ready) begin
                    if (wr_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = ST_RESPOND;
                    end else begin
                        state_d = ST_WAIT_RSP;
                    end
                end else if (timeout_c) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESPOND;
                end
            end

            ST_WAIT_RSP: begin
                timer_d = timeout_c ? timer_q : timer_q + TMR_W'(1);
                if (m_rdata_valid) begin
                    rdata_d = m_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESPOND;
                end else if (timeout_c) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESPOND;
                end
            end

            ST_RESPOND: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched fields and registered outputs, all decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'(REQ_A);
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            m_valid      <= 1'b0;
            m_write      <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            grant        <= 2'b00;
            busy         <= 1'b0;
            j_rsp_valid  <= 1'b0;
            j_rsp_rdata  <= '0;
            j_rsp_err    <= 1'b0;
            a_rsp_valid  <= 1'b0;
            a_rsp_rdata  <= '0;
            a_rsp_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            m_valid      <= (state_d == ST_ISSUE);
            m_write      <= wr_d;
            m_addr       <= addr_d;
            m_wdata      <= wdata_d;
            grant        <= (state_d != ST_IDLE) ? owner_onehot(owner_d) : 2'b00;
            busy         <= (state_d != ST_IDLE);
            j_rsp_valid  <= (state_d == ST_RESPOND) && (owner_d == 1'(REQ_J));
            j_rsp_rdata  <= rdata_d;
            j_rsp_err    <= err_d;
            a_rsp_valid  <= (state_d == ST_RESPOND) && (owner_d == 1'(REQ_A));
            a_rsp_rdata  <= rdata_d;
            a_rsp_err    <= err_d;
        end
    end

endmodule

// File: doc/neural_soc_debug_access_arbiter.md
Name: neural_soc_debug_access_arbiter

Overview:
- Shares the CPU's single on-chip-instrumentation (OCI) debug register/memory port between two requesters in the `clk` domain.
- Requester 0 is the JTAG debug slave command path, decoded from the sysclk-side take_action pulses and jdo. Requester 1 is an Avalon-side debug master used by on-chip software.
- Arbitrates one transaction at a time, sequences it onto the OCI port, waits for completion with a timeout, and returns the response to the owner.

Parameters:
- ADDR_W, 9, OCI word address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles a granted transaction may spend in ISSUE+WAIT_RSP; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- j_req_valid  in  1  JTAG request valid.
- j_req_ready  out  1  JTAG request accepted.
- j_req_write  in  1  1=write, 0=read.
- j_req_addr  in  ADDR_W  JTAG address.
- j_req_wdata  in  DATA_W  JTAG write data.
- j_rsp_valid  out  1  JTAG response pulse.
- j_rsp_rdata  out  DATA_W  JTAG read data.
- j_rsp_err  out  1  JTAG timeout error.
- a_req_valid, a_req_ready, a_req_write, a_req_addr, a_req_wdata, a_rsp_valid, a_rsp_rdata, a_rsp_err: same directions, widths and meanings as j_*, for the Avalon requester.
- debugack  in  1  CPU is in debug mode; gives JTAG strict priority.
- m_valid  out  1  OCI command valid.
- m_write  out  1  OCI command is a write.
- m_addr  out  ADDR_W  OCI address.
- m_wdata  out  DATA_W  OCI write data.
- m_ready  in  1  OCI accepts the command.
- m_rdata_valid  in  1  OCI read data valid.
- m_rdata  in  DATA_W  OCI read data.
- grant  out  2  one-hot current owner ({a,j}); 0 when idle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, any state, including mid-transaction):
  - state goes to IDLE; all outputs go to 0; latched fields, rdata and timer clear; last_grant becomes A, so JTAG wins the first tie.
  - An interrupted OCI command is dropped and no response is issued.
- States: IDLE, ISSUE, WAIT_RSP, RESPOND.
- IDLE:
  - Winner selection (combinational):
    - debugack & j_req_valid → J.
    - Otherwise, with only one valid → that requester.
    - Both valid → the requester not equal to last_grant (round-robin).
  - x_req_ready is asserted combinationally to the winner only. A transfer occurs on valid&ready in the same cycle.
  - On transfer: latch write/addr/wdata, set owner, clear timer, go to ISSUE.
  - The loser's ready stays 0; it holds its request, and its valid must stay stable.
  - x_req_ready is never asserted outside IDLE.
- ISSUE:
  - m_valid=1, driven with the latched fields (stable until accepted); timer increments each cycle.
  - On m_ready: a write goes to RESPOND (err=0, rdata=0); a read goes to WAIT_RSP.
  - m_rdata_valid is ignored in ISSUE.
- WAIT_RSP:
  - m_valid=0.
  - On m_rdata_valid: latch m_rdata, go to RESPOND (err=0).
- Timeout (ISSUE or WAIT_RSP):
  - When timer==TIMEOUT and no completion occurs that cycle: go to RESPOND with err=1, rdata=0, and deassert m_valid.
  - Completion in the same cycle as the timeout wins (err=0).
- RESPOND:
  - x_rsp_valid=1 for exactly one cycle to the owner only, with rsp_rdata/rsp_err held valid in that cycle. There is no response backpressure.
  - last_grant←owner; go to IDLE. A new grant is possible the next cycle.
- Latency, best case:
  - write: accept at T, m_valid/m_ready at T+1, rsp_valid at T+2.
  - read: accept at T, m_ready at T+1, m_rdata_valid at T+2, rsp_valid at T+3.
- Timer width is clog2(TIMEOUT+1) and saturates, with no wrap.
- Stray m_rdata_valid in IDLE/RESPOND is ignored.
- grant is one-hot to the owner from ISSUE through RESPOND.
- Only one transaction is outstanding at any time.

Decomposition:
- Shared package neural_soc_debug_pkg:
  - state enum {IDLE, ISSUE, WAIT_RSP, RESPOND};
  - requester index constants REQ_J=0, REQ_A=1;
  - default ADDR_W/DATA_W/TIMEOUT constants.
- One natural sub-module: neural_soc_debug_rr_pick, the 2-way round-robin selector with a priority override (inputs: valids, last_grant, debugack; output: one-hot winner).

Test Plan:
- JTAG write addr 0x1A5, data 0xDEADBEEF, m_ready at first ISSUE cycle → m_addr=0x1A5, m_wdata=0xDEADBEEF, m_write=1; j_rsp_valid exactly 2 cycles after accept, err=0; a_rsp_valid stays 0.
- Avalon read addr 0x004, m_rdata_valid=1 with 0x12345678 three cycles after m_ready → a_rsp_rdata=0x12345678, err=0, delivered one cycle after m_rdata_valid.
- Both valid continuously, debugack=0, 4 transactions each → grants alternate J,A,J,A… starting with J after reset.
- Both valid, debugack=1 → J granted every time while asserted; A is granted only after J deasserts valid.
- Read with m_rdata_valid never asserted, TIMEOUT=8 → rsp_valid with err=1, rdata=0 in the cycle after timer hits 8. A late m_rdata_valid is then ignored and the next request proceeds normally.
- reset asserted for one cycle while in WAIT_RSP → next cycle busy=0, grant=0, m_valid=0, no rsp_valid; a fresh J/A tie then grants J.
